// File: rtl/run_result_checker.sv
// run_result_checker: detects end of a CPU run, then compares register file and a DM window against golden images
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  one-cycle pulse starting a run (accepted in IDLE or DONE)
//   halt_req_i, pc_i         core completion signals watched during RUN
//   rf_raddr_o / rf_rdata_i  register-file synchronous read port
//   dm_raddr_o / dm_rdata_i  data-memory synchronous read port
//   gold_sel_o, gold_raddr_o, gold_rdata_i  golden image read port (0 = registers, 1 = memory)
//   busy_o, done_o, pass_o, timeout_o       run status
//   err_cnt_o, first_err_*_o                mismatch count (saturating) and first mismatch location
//   cycle_cnt_o                             RUN cycles elapsed (saturating)
module run_result_checker #(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int MEM_AW      = 12,
  parameter int MEM_LO      = 0,
  parameter int MEM_HI      = 4095,
  parameter int PC_W        = 10,
  parameter int HALT_STABLE = 4,
  parameter int MAX_CYCLES  = 50000,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              halt_req_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic [REG_AW-1:0] rf_raddr_o,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [MEM_AW-1:0] dm_raddr_o,
  input  logic [DATA_W-1:0] dm_rdata_i,
  output logic              gold_sel_o,
  output logic [MEM_AW-1:0] gold_raddr_o,
  input  logic [DATA_W-1:0] gold_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              first_err_valid_o,
  output logic              first_err_sel_o,
  output logic [MEM_AW-1:0] first_err_addr_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);
  typedef enum logic [2:0] {IDLE, RUN, SCAN_REG, SCAN_MEM, DONE} state_e;
  localparam int SW = $clog2(HALT_STABLE + 1);
  localparam logic [MEM_AW-1:0] LO = MEM_AW'(MEM_LO);
  localparam logic [MEM_AW-1:0] HI = MEM_AW'(MEM_HI);
  localparam logic [REG_AW-1:0] REG_LAST = '1;
  state_e            state_q;
  logic [PC_W-1:0]   pc_q;
  logic [SW-1:0]     stable_q, stable_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d, err_cnt_q;
  logic [REG_AW-1:0] rf_raddr_q;
  logic [MEM_AW-1:0] dm_raddr_q, gold_raddr_q, cmp_addr_q, first_err_addr_q;
  logic              gold_sel_q, busy_q, done_q, timeout_q;
  logic              first_err_valid_q, first_err_sel_q;
  logic              mem_last_q, cmp_valid_q, cmp_sel_q;
  logic              halt_d, tmo_d, mism_d;
  always_comb begin
    stable_d    = (pc_i == pc_q) ? stable_q + SW'(1) : '0;
    cycle_cnt_d = (&cycle_cnt_q) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    halt_d      = halt_req_i || (int'(stable_d) == HALT_STABLE - 1);
    tmo_d       = int'(cycle_cnt_q) == MAX_CYCLES - 1;
    // data requested last cycle is compared now; sel picks which read port it came from
    mism_d      = cmp_valid_q && ((cmp_sel_q ? dm_rdata_i : rf_rdata_i) != gold_rdata_i);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      pc_q              <= '0;
      stable_q          <= '0;
      cycle_cnt_q       <= '0;
      err_cnt_q         <= '0;
      rf_raddr_q        <= '0;
      dm_raddr_q        <= '0;
      gold_raddr_q      <= '0;
      gold_sel_q        <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      timeout_q         <= 1'b0;
      first_err_valid_q <= 1'b0;
      first_err_sel_q   <= 1'b0;
      first_err_addr_q  <= '0;
      mem_last_q        <= 1'b0;
      cmp_valid_q       <= 1'b0;
      cmp_sel_q         <= 1'b0;
      cmp_addr_q        <= '0;
    end else begin
      pc_q        <= pc_i;
      // an address issued this cycle is compared next cycle; the extra SCAN_MEM cycle issues nothing
      cmp_valid_q <= (state_q == SCAN_REG) || (state_q == SCAN_MEM && !mem_last_q);
      cmp_sel_q   <= gold_sel_q;
      cmp_addr_q  <= gold_raddr_q;
      if (mism_d) begin
        err_cnt_q <= (&err_cnt_q) ? err_cnt_q : err_cnt_q + CNT_W'(1);
        if (!first_err_valid_q) begin
          first_err_valid_q <= 1'b1;
          first_err_sel_q   <= cmp_sel_q;
          first_err_addr_q  <= cmp_addr_q;
        end
      end
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q           <= RUN;
            busy_q            <= 1'b1;
            done_q            <= 1'b0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_sel_q   <= 1'b0;
            first_err_addr_q  <= '0;
            timeout_q         <= 1'b0;
            cycle_cnt_q       <= '0;
            stable_q          <= '0;
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
          stable_q    <= stable_d;
          if (halt_d || tmo_d) begin
            state_q      <= SCAN_REG;
            timeout_q    <= !halt_d;
            rf_raddr_q   <= '0;
            gold_raddr_q <= '0;
            gold_sel_q   <= 1'b0;
          end
        end
        SCAN_REG: begin
          if (rf_raddr_q == REG_LAST) begin
            state_q      <= SCAN_MEM;
            dm_raddr_q   <= LO;
            gold_raddr_q <= LO;
            gold_sel_q   <= 1'b1;
            mem_last_q   <= 1'b0;
          end else begin
            rf_raddr_q   <= rf_raddr_q + REG_AW'(1);
            gold_raddr_q <= gold_raddr_q + MEM_AW'(1);
          end
        end
        SCAN_MEM: begin
          if (mem_last_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (dm_raddr_q == HI) begin
            mem_last_q <= 1'b1;
          end else begin
            dm_raddr_q   <= dm_raddr_q + MEM_AW'(1);
            gold_raddr_q <= gold_raddr_q + MEM_AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rf_raddr_o        = rf_raddr_q;
  assign dm_raddr_o        = dm_raddr_q;
  assign gold_raddr_o      = gold_raddr_q;
  assign gold_sel_o        = gold_sel_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign timeout_o         = timeout_q;
  assign pass_o            = done_q && (err_cnt_q == '0) && !timeout_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_sel_o   = first_err_sel_q;
  assign first_err_addr_o  = first_err_addr_q;
  assign cycle_cnt_o       = cycle_cnt_q;
endmodule

// File: tb/tb_run_result_checker.sv
// tb_run_result_checker: randomized directed runs of three checker configurations against a behavioural model
module tb_run_result_checker;
  localparam int HS = 4;
  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        halt_req = 1'b0;
  logic [9:0]  pc = '0;
  logic        start [3];
  logic [4:0]  rf_raddr [3];
  logic [11:0] dm_raddr [3];
  logic [11:0] gold_raddr [3];
  logic        gold_sel [3];
  logic [31:0] rf_rdata [3];
  logic [31:0] dm_rdata [3];
  logic [31:0] gold_rdata [3];
  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic        timeout [3];
  logic        fev [3];
  logic        fes [3];
  logic [11:0] fea [3];
  logic [15:0] err_a, err_b, cyc_a, cyc_b;
  logic [3:0]  err_c, cyc_c;
  logic [31:0] rf [32];
  logic [31:0] grf [32];
  logic [31:0] dm [4096];
  logic [31:0] gdm [4096];
  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  run_result_checker dut_a (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start[0]), .halt_req_i(halt_req), .pc_i(pc),
    .rf_raddr_o(rf_raddr[0]), .rf_rdata_i(rf_rdata[0]), .dm_raddr_o(dm_raddr[0]), .dm_rdata_i(dm_rdata[0]),
    .gold_sel_o(gold_sel[0]), .gold_raddr_o(gold_raddr[0]), .gold_rdata_i(gold_rdata[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .timeout_o(timeout[0]), .err_cnt_o(err_a),
    .first_err_valid_o(fev[0]), .first_err_sel_o(fes[0]), .first_err_addr_o(fea[0]), .cycle_cnt_o(cyc_a));
  run_result_checker #(.MEM_LO(16), .MEM_HI(47), .MAX_CYCLES(50)) dut_b (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start[1]), .halt_req_i(halt_req), .pc_i(pc),
    .rf_raddr_o(rf_raddr[1]), .rf_rdata_i(rf_rdata[1]), .dm_raddr_o(dm_raddr[1]), .dm_rdata_i(dm_rdata[1]),
    .gold_sel_o(gold_sel[1]), .gold_raddr_o(gold_raddr[1]), .gold_rdata_i(gold_rdata[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .timeout_o(timeout[1]), .err_cnt_o(err_b),
    .first_err_valid_o(fev[1]), .first_err_sel_o(fes[1]), .first_err_addr_o(fea[1]), .cycle_cnt_o(cyc_b));
  run_result_checker #(.MEM_LO(16), .MEM_HI(47), .CNT_W(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start[2]), .halt_req_i(halt_req), .pc_i(pc),
    .rf_raddr_o(rf_raddr[2]), .rf_rdata_i(rf_rdata[2]), .dm_raddr_o(dm_raddr[2]), .dm_rdata_i(dm_rdata[2]),
    .gold_sel_o(gold_sel[2]), .gold_raddr_o(gold_raddr[2]), .gold_rdata_i(gold_rdata[2]),
    .busy_o(busy[2]), .done_o(done[2]), .pass_o(pass[2]), .timeout_o(timeout[2]), .err_cnt_o(err_c),
    .first_err_valid_o(fev[2]), .first_err_sel_o(fes[2]), .first_err_addr_o(fea[2]), .cycle_cnt_o(cyc_c));
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rf_rdata[i]   <= rf[rf_raddr[i]];
      dm_rdata[i]   <= dm[dm_raddr[i]];
      gold_rdata[i] <= gold_sel[i] ? gdm[gold_raddr[i]] : grf[gold_raddr[i][4:0]];
    end
  end
  function automatic int lo_of(input int w);
    return (w == 0) ? 0 : 16;
  endfunction
  function automatic int hi_of(input int w);
    return (w == 0) ? 4095 : 47;
  endfunction
  function automatic int maxc_of(input int w);
    return (w == 1) ? 50 : 50000;
  endfunction
  function automatic int cmax_of(input int w);
    return (w == 2) ? 15 : 65535;
  endfunction
  function automatic logic [15:0] err_of(input int w);
    return (w == 0) ? err_a : (w == 1) ? err_b : {12'h0, err_c};
  endfunction
  function automatic logic [15:0] cyc_of(input int w);
    return (w == 0) ? cyc_a : (w == 1) ? cyc_b : {12'h0, cyc_c};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input int w);
    chk("rst_busy", busy[w], 0);
    chk("rst_done", done[w], 0);
    chk("rst_pass", pass[w], 0);
    chk("rst_timeout", timeout[w], 0);
    chk("rst_err", err_of(w), 0);
    chk("rst_cycle", cyc_of(w), 0);
    chk("rst_fev", fev[w], 0);
    chk("rst_fes", fes[w], 0);
    chk("rst_fea", fea[w], 0);
    chk("rst_rf_raddr", rf_raddr[w], 0);
    chk("rst_dm_raddr", dm_raddr[w], 0);
    chk("rst_gold_raddr", gold_raddr[w], 0);
    chk("rst_gold_sel", gold_sel[w], 0);
  endtask
  task automatic fill_match();
    for (int i = 0; i < 32; i++) begin
      rf[i]  = $urandom;
      grf[i] = rf[i];
    end
    for (int i = 0; i < 4096; i++) begin
      dm[i]  = $urandom;
      gdm[i] = dm[i];
    end
  endtask
  // One complete run on DUT w: the reference decides the exit cycle from the pc/halt sequence and
  // the result from the images, then the DUT is driven cycle by cycle and compared.
  task automatic do_run(input int w, input int halt_at, input int freeze_at, input bit toggle,
                        input int glitch_at, input int abort_at);
    int pcs [0:300];
    int k, lat, cnt, fa, ecyc, len;
    bit tmo, fv, fs, eq;
    for (int i = 0; i <= 300; i++) begin
      if (toggle) pcs[i] = (i % 2 == 1) ? 'h10 : 'h20;
      else if (freeze_at != 0 && i >= freeze_at) pcs[i] = 'h3F;
      else if (i == 0) pcs[i] = int'($urandom_range(0, 1023));
      else pcs[i] = (pcs[i-1] + 1 + int'($urandom_range(0, 2))) % 1024;
    end
    if (freeze_at != 0 && pcs[freeze_at-1] == 'h3F) pcs[freeze_at-1] = 'h40;
    k = 0;
    tmo = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      eq = (i >= HS - 1);
      for (int j = i - HS + 1; eq && j < i; j++) if (pcs[j] != pcs[i]) eq = 0;
      if (i == halt_at || eq) k = i;
      else if (i == maxc_of(w)) begin
        k = i;
        tmo = 1;
      end
    end
    ecyc = (k > cmax_of(w)) ? cmax_of(w) : k;
    cnt = 0;
    fv = 0;
    fs = 0;
    fa = 0;
    for (int r = 0; r < 32; r++) if (rf[r] !== grf[r]) begin
      cnt++;
      if (!fv) begin fv = 1; fs = 0; fa = r; end
    end
    for (int m = lo_of(w); m <= hi_of(w); m++) if (dm[m] !== gdm[m]) begin
      cnt++;
      if (!fv) begin fv = 1; fs = 1; fa = m; end
    end
    len = 32 + (hi_of(w) - lo_of(w) + 1) + 1;
    @(negedge clk);
    start[w] = 1'b1;
    pc = 10'(pcs[0]);
    halt_req = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= k; i++) begin
      pc = 10'(pcs[i]);
      halt_req = (i == halt_at);
      start[w] = (i == glitch_at);
      @(negedge clk);
    end
    start[w] = 1'b0;
    halt_req = 1'b0;
    pc = 10'($urandom);
    chk("cycle_at_exit", cyc_of(w), 64'(ecyc));
    chk("busy_scan", busy[w], 1);
    chk("rf_raddr_first", rf_raddr[w], 0);
    chk("gold_sel_reg", gold_sel[w], 0);
    if (abort_at != 0) begin
      repeat (abort_at) @(negedge clk);
      rst_ni = 1'b0;
      #1;
      chk_zero(w);
      @(negedge clk);
      rst_ni = 1'b1;
      return;
    end
    @(negedge clk);
    chk("cycle_hold", cyc_of(w), 64'(ecyc));
    chk("rf_raddr_second", rf_raddr[w], 1);
    lat = 1;
    while (!done[w] && lat < len + 20) begin
      pc = 10'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("scan_latency", 64'(lat), 64'(len));
    chk("done", done[w], 1);
    chk("busy_done", busy[w], 0);
    chk("timeout", timeout[w], 64'(tmo));
    chk("err_cnt", err_of(w), 64'((cnt > cmax_of(w)) ? cmax_of(w) : cnt));
    chk("pass", pass[w], 64'(cnt == 0 && !tmo));
    chk("first_err_valid", fev[w], 64'(fv));
    if (fv) begin
      chk("first_err_sel", fes[w], 64'(fs));
      chk("first_err_addr", fea[w], 64'(fa));
    end
    chk("dm_raddr_hold", dm_raddr[w], 64'(hi_of(w)));
    chk("gold_raddr_hold", gold_raddr[w], 64'(hi_of(w)));
    chk("gold_sel_hold", gold_sel[w], 1);
    repeat (3) @(negedge clk);
    chk("done_hold", done[w], 1);
    chk("err_hold", err_of(w), 64'((cnt > cmax_of(w)) ? cmax_of(w) : cnt));
  endtask
  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    fill_match();
    repeat (3) @(negedge clk);
    for (int w = 0; w < 3; w++) chk_zero(w);
    rst_ni = 1'b1;
    @(negedge clk);
    // matching images, halt in the 100th RUN cycle, stray start mid-RUN
    do_run(0, 100, 0, 0, 50, 0);
    // register 7 and DM[0x010] differ
    fill_match();
    grf[7] = grf[7] ^ (32'h1 << $urandom_range(0, 31));
    gdm['h10] = gdm['h10] ^ (32'h1 << $urandom_range(0, 31));
    do_run(0, int'($urandom_range(20, 150)), 0, 0, 0, 0);
    // scattered random memory mismatches
    fill_match();
    repeat (6) begin
      int a;
      a = int'($urandom_range(0, 4095));
      gdm[a] = gdm[a] ^ (32'h1 << $urandom_range(0, 31));
    end
    do_run(0, int'($urandom_range(5, 200)), 0, 0, 0, 0);
    // pc frozen at 0x3F with no halt request
    fill_match();
    do_run(0, 0, int'($urandom_range(10, 60)), 0, 0, 0);
    // reset during SCAN_MEM, then a clean full check with a stray start in RUN
    do_run(0, 40, 0, 0, 0, 1000);
    fill_match();
    do_run(0, int'($urandom_range(30, 90)), 0, 0, 7, 0);
    // timeout with toggling pc and matching data
    fill_match();
    do_run(1, 0, 0, 1, 0, 0);
    // halt on the timeout cycle wins; mismatches at MEM_HI and just outside the window
    gdm[47] = gdm[47] ^ 32'h1;
    gdm[15] = gdm[15] ^ 32'h2;
    gdm[48] = gdm[48] ^ 32'h4;
    do_run(1, 50, 0, 1, 0, 0);
    // every register mismatched on a 4-bit counter configuration
    fill_match();
    for (int r = 0; r < 32; r++) grf[r] = ~rf[r];
    do_run(2, 30, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/run_result_checker.md
Name: run_result_checker

Overview:
- Synthesizable end-of-run checker for CPU regression. Replaces the fixed-length run and golden dump-compare done by hand in the CPU testbench.
- Watches the running core and detects completion, either by a halt request, a stalled PC or a cycle-limit timeout.
- After completion, scans the register file and a data-memory window against golden images through synchronous read ports. Reports pass/fail, an error count and the first mismatch.
- Sits beside the CPU top inside the bench harness, or on-chip for self-test.

Parameters:
- DATA_W, 32, word width of register, DM and golden data
- REG_AW, 5, register-file address width; REG_N = 2**REG_AW registers scanned
- MEM_AW, 12, DM address width
- MEM_LO, 0, first DM address scanned
- MEM_HI, 4095, last DM address scanned (inclusive, MEM_HI >= MEM_LO)
- PC_W, 10, PC width
- HALT_STABLE, 4, consecutive cycles of unchanged PC that count as halted
- MAX_CYCLES, 50000, RUN-phase cycle limit
- CNT_W, 16, width of the error and cycle counters

Ports:
- clk, in, 1, clock
- rst, in, 1, asynchronous reset, active-low
- start, in, 1, one-cycle pulse; begins RUN phase; ignored unless in IDLE or DONE
- halt_req, in, 1, explicit halt from the core
- pc, in, PC_W, current core PC
- rf_raddr, out, REG_AW, register-file read address
- rf_rdata, in, DATA_W, register data; valid 1 cycle after rf_raddr
- dm_raddr, out, MEM_AW, DM read address
- dm_rdata, in, DATA_W, DM data; valid 1 cycle after dm_raddr
- gold_sel, out, 1, 0 = register golden, 1 = memory golden
- gold_raddr, out, MEM_AW, golden address (register index zero-extended)
- gold_rdata, in, DATA_W, golden data; valid 1 cycle after gold_raddr
- busy, out, 1, high in RUN, SCAN_REG and SCAN_MEM
- done, out, 1, high in DONE
- pass, out, 1, done and err_cnt == 0 and not timeout
- timeout, out, 1, RUN ended by MAX_CYCLES
- err_cnt, out, CNT_W, mismatch count; saturates at all-ones
- first_err_valid, out, 1, first mismatch captured
- first_err_sel, out, 1, 0 = register, 1 = memory
- first_err_addr, out, MEM_AW, address of the first mismatch
- cycle_cnt, out, CNT_W, RUN cycles elapsed; saturates

Behaviour:
- Reset (rst low): all outputs, addresses and counters go to 0; state becomes IDLE. Reset asserted mid-scan aborts the scan immediately.
- States: IDLE -> RUN -> SCAN_REG -> SCAN_MEM -> DONE -> (start) RUN.
- start accepted in IDLE or DONE. On the accepting edge: clear err_cnt, first_err_*, timeout, cycle_cnt and the stable counter; enter RUN. start in other states has no effect.
- RUN, each cycle:
  - cycle_cnt increments.
  - Stable counter increments when pc equals the previous-cycle pc, and resets to 0 otherwise.
  - Exit to SCAN_REG on halt_req, or when the stable counter reaches HALT_STABLE-1 (i.e. HALT_STABLE equal samples).
  - Exit when cycle_cnt reaches MAX_CYCLES-1; in that case timeout=1.
  - If both exit conditions hold in the same cycle, halt wins: timeout stays 0.
- SCAN_REG:
  - Issues addresses 0..REG_N-1 on rf_raddr and gold_raddr, with gold_sel=0, one address per cycle.
  - Compare is pipelined 1 cycle: the address and sel are registered and compared against the returned data the next cycle.
  - Enters SCAN_MEM once the last address is issued; the final compare completes in the first SCAN_MEM cycle.
- SCAN_MEM:
  - Issues MEM_LO..MEM_HI on dm_raddr and gold_raddr, with gold_sel=1.
  - Moves to DONE one cycle after MEM_HI is issued, so the last compare lands.
- Mismatch (rdata != gold_rdata):
  - err_cnt increments, saturating at all-ones.
  - If first_err_valid=0, capture sel and addr and set first_err_valid.
- Total scan latency: REG_N + (MEM_HI-MEM_LO+1) + 1 cycles from leaving RUN to done.
- DONE: outputs hold until start or reset. busy=0, done=1.
- Address outputs hold their last value outside the scan states.

Test Plan:
- Matching images; halt_req at cycle 100 -> done after 32+4096+1 scan cycles, pass=1, err_cnt=0, timeout=0, cycle_cnt=100.
- Register 7 golden differs, DM[0x010] differs -> err_cnt=2, first_err_sel=0, first_err_addr=7, pass=0.
- pc frozen at 0x3F, no halt_req -> RUN exits exactly 4 cycles after the freeze begins; scan follows.
- pc toggling, no halt, MAX_CYCLES=50 -> timeout=1, cycle_cnt=50, pass=0 even with matching data.
- rst low mid SCAN_MEM -> all outputs 0, IDLE; a subsequent start runs a clean full check; start pulsed during RUN is ignored.
- All 32 registers mismatched with CNT_W=4 -> err_cnt saturates at 15; first_err_addr=0.
